ldpc_layer_scheduler: RTL and testbench
=======================================

// Module: ldpc_layer_scheduler
// PURPOSE
//  Top-level sequencer for the layered min-sum LDPC decoder datapath. It walks the base-graph rows
//  (layers) through the VN_UPDATE, BARREL_SHIFT, CN_UPDATE and REVERSE_SHIFT stages, then runs a
//  parity check after each iteration. It stops early when the syndrome is zero, or after
//  cfg_max_iter iterations, and reports the result. It sits between the host config/start
//  interface and the VN/CN/shifter datapath.
// PARAMETERS
//  MAX_ITER     15    hard ceiling on iterations (ldpc_decoder_pkg::MAX_ITERATIONS)
//  MB_MAX       68    largest supported base-graph row count (BG1_MB)
//  ROW_W        7     width of row index, $clog2(MB_MAX)
//  ITER_W       4     width of iteration counter, $clog2(MAX_ITER+1)
//  TIMEOUT_CYC  1023  max cycles spent waiting in any one stage before ERROR
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous, active-high reset
//  start          in   1       one-cycle request to begin a codeword; honoured only in IDLE
//  abort          in   1       force return to IDLE from any state
//  cfg_mb         in   8       layers to process (rows of the active base graph)
//  cfg_max_iter   in   ITER_W  iteration limit, 1..MAX_ITER
//  stage_start    out  1       one-cycle pulse: datapath begins the stage named by state
//  stage_done     in   1       datapath finished the current stage
//  parity_valid   in   1       syndrome result valid (CHECK_PARITY only)
//  syndrome_zero  in   1       all parity checks satisfied; qualified by parity_valid
//  state          out  4       current decoder_state_t
//  row_idx        out  ROW_W   current layer, 0..cfg_mb-1
//  iter_count     out  ITER_W  completed iterations
//  busy           out  1       high in every state except IDLE, DONE and ERROR
//  done           out  1       one-cycle pulse on DONE
//  success        out  1       held from DONE until next start: 1 = converged
//  error          out  1       high while in ERROR
// BEHAVIOUR
//  - Reset: state=IDLE, all counters 0, all outputs 0.
//  - IDLE: start -> LOAD_CONFIG. In LOAD_CONFIG, latch cfg_mb and cfg_max_iter and clear success.
//    If cfg_mb==0, cfg_mb>MB_MAX, cfg_max_iter==0 or cfg_max_iter>MAX_ITER -> ERROR;
//    otherwise -> INIT_MESSAGES. Cfg inputs are ignored outside LOAD_CONFIG.
//  - Stage states (INIT_MESSAGES, VN_UPDATE, BARREL_SHIFT, CN_UPDATE, REVERSE_SHIFT,
//    CHECK_PARITY, HARD_DECISION):
//    - stage_start is asserted in the first cycle of each state entry.
//    - stage_done is ignored in that first cycle and sampled from the next cycle on.
//    - Minimum residence is therefore 2 cycles.
//  - Transitions (all on stage_done unless stated):
//    - INIT_MESSAGES -> VN_UPDATE, with row=0, iter=0.
//    - VN_UPDATE -> BARREL_SHIFT -> CN_UPDATE -> REVERSE_SHIFT.
//    - REVERSE_SHIFT: if row<mb-1, row++ and -> VN_UPDATE; else -> CHECK_PARITY.
//    - CHECK_PARITY, on parity_valid (stage_done is not used here), iter_count++, then:
//      - syndrome_zero=1 -> HARD_DECISION, success_nxt=1;
//      - else iter_count==max_iter -> HARD_DECISION, success_nxt=0;
//      - else row=0 -> VN_UPDATE.
//    - HARD_DECISION -> DONE.
//  - DONE: done=1 for exactly one cycle, success valid, then -> IDLE. A start in DONE is ignored.
//  - ERROR: error held high. Exit only via abort or rst. start is ignored.
//  - Watchdog: a cycle counter is cleared on every state entry. When it reaches TIMEOUT_CYC in a
//    stage state -> ERROR (stage_start is not reissued).
//  - abort: wins over every other event in the same cycle. Next state is IDLE. No done pulse;
//    success is cleared.
//  - Event precedence in one cycle: rst > abort > watchdog > stage_done/parity_valid.
//  - row_idx and iter_count are frozen in DONE and ERROR for debug readout. Both are zeroed on
//    the next LOAD_CONFIG.
//  - Counters are unsigned and never wrap: row is bounded by cfg_mb and iter by cfg_max_iter.
// STRUCTURE
//  - ldpc_decoder_pkg supplies decoder_state_t, MAX_ITERATIONS and BG1_MB.
//  - Add a new package typedef sched_cfg_t {mb, max_iter} and the constant SCHED_TIMEOUT_CYC.
//  - One sub-module: ldpc_stage_watchdog (clear, enable, expire), holding the timeout counter.
//  - Everything else is a single FSM plus row/iteration counters.
// TESTING
//  1. cfg_mb=4, max_iter=3, stage_done 1 cycle after every stage_start, syndrome_zero=1 on the
//     first check -> done after iter_count=1, success=1, 16 VN/BS/CN/RS stage_start pulses.
//  2. cfg_mb=2, max_iter=3, syndrome_zero never set -> 3 CHECK_PARITY visits, iter_count=3,
//     done pulse, success=0.
//  3. cfg_mb=0, and separately cfg_max_iter=0 -> ERROR on the cycle after LOAD_CONFIG, busy=0,
//     start ignored; abort -> IDLE next cycle.
//  4. Hold stage_done low in CN_UPDATE with TIMEOUT_CYC=8 -> ERROR exactly 8 cycles after entry,
//     row_idx preserved.
//  5. Assert abort at the same time as stage_done in REVERSE_SHIFT of the last row -> IDLE,
//     no CHECK_PARITY, no done, success=0.
//  6. stage_done held high continuously (including the stage_start cycle) -> each stage lasts
//     exactly 2 cycles; assert rst mid-decode -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ldpc_decoder_pkg.sv
// Shared decoder-wide constants and the top-level decoder state encoding.
package ldpc_decoder_pkg;

    localparam int MAX_ITERATIONS = 15;
    localparam int BG1_MB         = 68;

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        LOAD_CONFIG   = 4'd1,
        INIT_MESSAGES = 4'd2,
        VN_UPDATE     = 4'd3,
        BARREL_SHIFT  = 4'd4,
        CN_UPDATE     = 4'd5,
        REVERSE_SHIFT = 4'd6,
        CHECK_PARITY  = 4'd7,
        HARD_DECISION = 4'd8,
        DONE          = 4'd9,
        ERROR         = 4'd10
    } decoder_state_t;

endpackage

// File: rtl/ldpc_layer_scheduler_pkg.sv
// Scheduler-local types: latched run configuration, watchdog default, stage classification.
package ldpc_layer_scheduler_pkg;

    import ldpc_decoder_pkg::*;

    localparam int SCHED_TIMEOUT_CYC = 1023;
    localparam int SCHED_ITER_W      = $clog2(MAX_ITERATIONS + 1);

    typedef struct packed {
        logic [7:0]              mb;
        logic [SCHED_ITER_W-1:0] max_iter;
    } sched_cfg_t;

    // States that hand work to the datapath and wait for it to finish.
    function automatic logic is_stage_state(input decoder_state_t s);
        return s inside {INIT_MESSAGES, VN_UPDATE, BARREL_SHIFT, CN_UPDATE,
                         REVERSE_SHIFT, CHECK_PARITY, HARD_DECISION};
    endfunction

endpackage

// File: rtl/ldpc_stage_watchdog.sv
// Residence-time counter for a single stage; expires on the TIMEOUT_CYC-th cycle spent in it.
module ldpc_stage_watchdog #(
    parameter int TIMEOUT_CYC = 1023,
    localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [CNT_W-1:0] count_reg;

    // Count is 0 in the entry cycle, so a match on TIMEOUT_CYC-1 lands the exit exactly
    // TIMEOUT_CYC cycles after entry.
    assign expire = enable && (count_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable && !expire) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ldpc_layer_scheduler.sv
// Layered min-sum decode sequencer: walks layers through the four datapath stages per
// iteration, checks parity after each pass, and reports convergence or failure.
module ldpc_layer_scheduler
    import ldpc_decoder_pkg::*;
    import ldpc_layer_scheduler_pkg::*;
#(
    parameter int MAX_ITER    = MAX_ITERATIONS,
    parameter int MB_MAX      = BG1_MB,
    parameter int ROW_W       = $clog2(MB_MAX),
    parameter int ITER_W      = SCHED_ITER_W,
    parameter int TIMEOUT_CYC = SCHED_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_mb,
    input  logic [ITER_W-1:0] cfg_max_iter,
    output logic              stage_start,
    input  logic              stage_done,
    input  logic              parity_valid,
    input  logic              syndrome_zero,
    output logic [3:0]        state,
    output logic [ROW_W-1:0]  row_idx,
    output logic [ITER_W-1:0] iter_count,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic              error
);

    decoder_state_t    state_reg, state_next;
    sched_cfg_t        cfg_reg, cfg_next;
    logic [ROW_W-1:0]  row_reg, row_next;
    logic [ITER_W-1:0] iter_reg, iter_next;
    logic              conv_reg, conv_next;
    logic              stage_start_reg, done_reg, success_reg, error_reg, busy_reg;
    logic              advance, expire, cfg_bad, last_row, last_iter;

    ldpc_stage_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_next != state_reg),
        .enable (is_stage_state(state_reg)),
        .expire (expire)
    );

    // The entry cycle (stage_start high) never completes a stage, even if done is already up.
    assign advance   = !stage_start_reg &&
                       ((state_reg == CHECK_PARITY) ? parity_valid : stage_done);
    assign cfg_bad   = (cfg_mb == 8'd0) || (int'(cfg_mb) > MB_MAX) ||
                       (cfg_max_iter == '0) || (int'(cfg_max_iter) > MAX_ITER);
    assign last_row  = (int'(row_reg) + 1) >= int'(cfg_reg.mb);
    assign last_iter = (iter_reg + ITER_W'(1)) == ITER_W'(cfg_reg.max_iter);

    always_comb begin
        state_next = state_reg;
        cfg_next   = cfg_reg;
        row_next   = row_reg;
        iter_next  = iter_reg;
        conv_next  = conv_reg;
        if (abort) begin
            state_next = IDLE;
        end else if (expire) begin
            state_next = ERROR;
        end else begin
            unique case (state_reg)
                IDLE: if (start) state_next = LOAD_CONFIG;
                LOAD_CONFIG: begin
                    cfg_next.mb       = cfg_mb;
                    cfg_next.max_iter = SCHED_ITER_W'(cfg_max_iter);
                    row_next          = '0;
                    iter_next         = '0;
                    conv_next         = 1'b0;
                    state_next        = cfg_bad ? ERROR : INIT_MESSAGES;
                end
                INIT_MESSAGES: if (advance) begin
                    row_next   = '0;
                    iter_next  = '0;
                    state_next = VN_UPDATE;
                end
                VN_UPDATE:     if (advance) state_next = BARREL_SHIFT;
                BARREL_SHIFT:  if (advance) state_next = CN_UPDATE;
                CN_UPDATE:     if (advance) state_next = REVERSE_SHIFT;
                REVERSE_SHIFT: if (advance) begin
                    if (last_row) begin
                        state_next = CHECK_PARITY;
                    end else begin
                        row_next   = row_reg + ROW_W'(1);
                        state_next = VN_UPDATE;
                    end
                end
                CHECK_PARITY: if (advance) begin
                    iter_next = iter_reg + ITER_W'(1);
                    conv_next = syndrome_zero;
                    if (syndrome_zero || last_iter) begin
                        state_next = HARD_DECISION;
                    end else begin
                        row_next   = '0;
                        state_next = VN_UPDATE;
                    end
                end
                HARD_DECISION: if (advance) state_next = DONE;
                DONE:          state_next = IDLE;
                ERROR:         state_next = ERROR;
                default:       state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cfg_reg         <= '0;
            row_reg         <= '0;
            iter_reg        <= '0;
            conv_reg        <= 1'b0;
            stage_start_reg <= 1'b0;
            done_reg        <= 1'b0;
            success_reg     <= 1'b0;
            error_reg       <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cfg_reg         <= cfg_next;
            row_reg         <= row_next;
            iter_reg        <= iter_next;
            conv_reg        <= conv_next;
            stage_start_reg <= (state_next != state_reg) && is_stage_state(state_next);
            done_reg        <= (state_next == DONE);
            error_reg       <= (state_next == ERROR);
            busy_reg        <= !(state_next inside {IDLE, DONE, ERROR});
            if (abort || state_reg == LOAD_CONFIG) begin
                success_reg <= 1'b0;
            end else if (state_next == DONE) begin
                success_reg <= conv_reg;
            end
        end
    end

    assign state       = state_reg;
    assign row_idx     = row_reg;
    assign iter_count  = iter_reg;
    assign stage_start = stage_start_reg;
    assign done        = done_reg;
    assign success     = success_reg;
    assign error       = error_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
// Directed bench for ldpc_layer_scheduler with a short watchdog so timeout paths are reachable.
module tb_ldpc_layer_scheduler;
    import ldpc_decoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cfg_mb = 8'd0;
    logic [3:0] cfg_max_iter = 4'd0;
    logic       stage_start;
    logic       stage_done = 1'b0;
    logic       parity_valid = 1'b0;
    logic       syndrome_zero = 1'b0;
    logic [3:0] state;
    logic [6:0] row_idx;
    logic [3:0] iter_count;
    logic       busy, done, success, error;

    int pass_cnt = 0;
    int total_cnt = 0;

    ldpc_layer_scheduler #(
        .TIMEOUT_CYC (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cfg_mb        (cfg_mb),
        .cfg_max_iter  (cfg_max_iter),
        .stage_start   (stage_start),
        .stage_done    (stage_done),
        .parity_valid  (parity_valid),
        .syndrome_zero (syndrome_zero),
        .state         (state),
        .row_idx       (row_idx),
        .iter_count    (iter_count),
        .busy          (busy),
        .done          (done),
        .success       (success),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Datapath responder: finish each stage one cycle after its stage_start.
    task automatic respond(input logic synd);
        stage_done    = !stage_start && (state inside {INIT_MESSAGES, VN_UPDATE, BARREL_SHIFT,
                                                       CN_UPDATE, REVERSE_SHIFT, HARD_DECISION});
        parity_valid  = !stage_start && (state == CHECK_PARITY);
        syndrome_zero = synd;
    endtask

    task automatic kick(input logic [7:0] mb, input logic [3:0] mi);
        cfg_mb = mb;
        cfg_max_iter = mi;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_decode(input logic [7:0] mb, input logic [3:0] mi, input int zero_at,
                              output int pulses, output int checks, output logic succ,
                              output logic [3:0] it, output logic [6:0] row, output logic ok);
        pulses = 0; checks = 0; succ = 1'b0; it = '0; row = '0; ok = 1'b0;
        kick(mb, mi);
        for (int c = 0; c < 3000; c++) begin
            if (stage_start && (state inside {VN_UPDATE, BARREL_SHIFT, CN_UPDATE, REVERSE_SHIFT}))
                pulses++;
            if (stage_start && state == CHECK_PARITY) checks++;
            if (done) begin
                succ = success; it = iter_count; row = row_idx; ok = 1'b1;
                break;
            end
            respond(checks == zero_at);
            tick();
        end
        stage_done = 1'b0; parity_valid = 1'b0; syndrome_zero = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total_cnt++;
        if ({state, stage_start, row_idx, iter_count, busy, done, success, error} !== '0)
            $display("FAIL reset_outputs: got state=%0d ss=%0b row=%0d it=%0d busy=%0b done=%0b succ=%0b err=%0b expected all 0",
                     state, stage_start, row_idx, iter_count, busy, done, success, error);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        $display("test_reset: state=%0d busy=%0b", state, busy);
    endtask

    task automatic test_converge();
        int p, ch; logic s, ok; logic [3:0] it; logic [6:0] row;
        run_decode(8'd4, 4'd3, 1, p, ch, s, it, row, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL conv_done_seen: got %0b expected 1", ok); else pass_cnt++;
        total_cnt++;
        if (p !== 16) $display("FAIL conv_stage_pulses: got %0d expected 16", p); else pass_cnt++;
        total_cnt++;
        if (it !== 4'd1) $display("FAIL conv_iter: got %0d expected 1", it); else pass_cnt++;
        total_cnt++;
        if (s !== 1'b1) $display("FAIL conv_success: got %0b expected 1", s); else pass_cnt++;
        total_cnt++;
        if (row !== 7'd3) $display("FAIL conv_row_frozen: got %0d expected 3", row); else pass_cnt++;
        // start while in DONE must not relaunch
        start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (state !== 4'(IDLE) || done !== 1'b0)
            $display("FAIL start_in_done: got state=%0d done=%0b expected state=%0d done=0", state, done, IDLE);
        else pass_cnt++;
        total_cnt++;
        if (success !== 1'b1) $display("FAIL success_held: got %0b expected 1", success); else pass_cnt++;
        $display("test_converge: pulses=%0d checks=%0d iter=%0d success=%0b", p, ch, it, s);
    endtask

    task automatic test_max_iter();
        int p, ch; logic s, ok; logic [3:0] it; logic [6:0] row;
        run_decode(8'd2, 4'd3, 0, p, ch, s, it, row, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL maxit_done_seen: got %0b expected 1", ok); else pass_cnt++;
        total_cnt++;
        if (ch !== 3) $display("FAIL maxit_checks: got %0d expected 3", ch); else pass_cnt++;
        total_cnt++;
        if (it !== 4'd3) $display("FAIL maxit_iter: got %0d expected 3", it); else pass_cnt++;
        total_cnt++;
        if (s !== 1'b0) $display("FAIL maxit_success: got %0b expected 0", s); else pass_cnt++;
        total_cnt++;
        if (p !== 24) $display("FAIL maxit_stage_pulses: got %0d expected 24", p); else pass_cnt++;
        tick();
        $display("test_max_iter: pulses=%0d checks=%0d iter=%0d success=%0b", p, ch, it, s);
    endtask

    task automatic test_bad_config();
        logic [7:0] mbs [3] = '{8'd0, 8'd5, 8'd69};
        logic [3:0] mis [3] = '{4'd3, 4'd0, 4'd2};
        for (int k = 0; k < 3; k++) begin
            kick(mbs[k], mis[k]);
            total_cnt++;
            if (state !== 4'(LOAD_CONFIG)) $display("FAIL bad_cfg%0d_load: got state %0d expected %0d", k, state, LOAD_CONFIG);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (state !== 4'(ERROR) || error !== 1'b1 || busy !== 1'b0)
                $display("FAIL bad_cfg%0d_error: got state=%0d err=%0b busy=%0b expected state=%0d err=1 busy=0",
                         k, state, error, busy, ERROR);
            else pass_cnt++;
            kick(8'd2, 4'd2);
            total_cnt++;
            if (state !== 4'(ERROR)) $display("FAIL bad_cfg%0d_start_ignored: got state %0d expected %0d", k, state, ERROR);
            else pass_cnt++;
            abort = 1'b1;
            tick();
            abort = 1'b0;
            total_cnt++;
            if (state !== 4'(IDLE) || error !== 1'b0)
                $display("FAIL bad_cfg%0d_abort: got state=%0d err=%0b expected state=0 err=0", k, state, error);
            else pass_cnt++;
            $display("test_bad_config: mb=%0d max_iter=%0d -> error then idle", mbs[k], mis[k]);
        end
    endtask

    task automatic test_watchdog();
        logic found = 1'b0;
        kick(8'd2, 4'd1);
        for (int c = 0; c < 200; c++) begin
            if (state == CN_UPDATE && stage_start && row_idx == 7'd1) begin
                found = 1'b1;
                break;
            end
            respond(1'b0);
            tick();
        end
        stage_done = 1'b0; parity_valid = 1'b0;
        total_cnt++;
        if (found !== 1'b1) $display("FAIL wd_reach_cn: got %0b expected 1", found); else pass_cnt++;
        repeat (7) tick();
        total_cnt++;
        if (state !== 4'(CN_UPDATE)) $display("FAIL wd_before_expiry: got state %0d expected %0d", state, CN_UPDATE);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (state !== 4'(ERROR) || error !== 1'b1 || stage_start !== 1'b0)
            $display("FAIL wd_expiry: got state=%0d err=%0b ss=%0b expected state=%0d err=1 ss=0",
                     state, error, stage_start, ERROR);
        else pass_cnt++;
        total_cnt++;
        if (row_idx !== 7'd1) $display("FAIL wd_row_kept: got %0d expected 1", row_idx); else pass_cnt++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("test_watchdog: error after 8 cycles in CN_UPDATE, row=1");
    endtask

    task automatic test_abort_last_row();
        logic found = 1'b0;
        int bad = 0;
        kick(8'd2, 4'd2);
        for (int c = 0; c < 200; c++) begin
            if (state == REVERSE_SHIFT && row_idx == 7'd1 && !stage_start) begin
                found = 1'b1;
                break;
            end
            respond(1'b0);
            tick();
        end
        total_cnt++;
        if (found !== 1'b1) $display("FAIL abort_reach_rs: got %0b expected 1", found); else pass_cnt++;
        stage_done = 1'b1; parity_valid = 1'b0; abort = 1'b1;
        tick();
        stage_done = 1'b0; abort = 1'b0;
        total_cnt++;
        if (state !== 4'(IDLE) || done !== 1'b0 || success !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_wins: got state=%0d done=%0b succ=%0b busy=%0b expected 0 0 0 0",
                     state, done, success, busy);
        else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            if (state == CHECK_PARITY || done) bad++;
            tick();
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL abort_quiet: got %0d check/done cycles expected 0", bad); else pass_cnt++;
        $display("test_abort_last_row: abort beat stage_done");
    endtask

    task automatic test_back_to_back();
        int bad = 0, stages = 0, run_len = 0;
        logic [3:0] prev;
        logic reached = 1'b0;
        stage_done = 1'b1; parity_valid = 1'b1; syndrome_zero = 1'b1;
        kick(8'd1, 4'd1);
        prev = state;
        run_len = 1;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (state != prev) begin
                if (prev inside {INIT_MESSAGES, VN_UPDATE, BARREL_SHIFT, CN_UPDATE,
                                 REVERSE_SHIFT, CHECK_PARITY, HARD_DECISION}) begin
                    stages++;
                    if (run_len != 2) bad++;
                end
                prev = state;
                run_len = 1;
            end else begin
                run_len++;
            end
            if (state == DONE) begin
                reached = 1'b1;
                break;
            end
        end
        total_cnt++;
        if (reached !== 1'b1) $display("FAIL b2b_done: got %0b expected 1", reached); else pass_cnt++;
        total_cnt++;
        if (bad !== 0) $display("FAIL b2b_residence: got %0d stages not lasting 2 cycles expected 0", bad); else pass_cnt++;
        total_cnt++;
        if (stages !== 7) $display("FAIL b2b_stage_count: got %0d expected 7", stages); else pass_cnt++;
        tick();
        // second run, reset part-way through
        reached = 1'b0;
        kick(8'd2, 4'd2);
        for (int c = 0; c < 100; c++) begin
            if (row_idx == 7'd1) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        total_cnt++;
        if (reached !== 1'b1 || busy !== 1'b1)
            $display("FAIL b2b_mid_decode: got reached=%0b busy=%0b expected 1 1", reached, busy);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({state, stage_start, row_idx, iter_count, busy, done, success, error} !== '0)
            $display("FAIL mid_reset: got state=%0d ss=%0b row=%0d it=%0d busy=%0b done=%0b succ=%0b err=%0b expected all 0",
                     state, stage_start, row_idx, iter_count, busy, done, success, error);
        else pass_cnt++;
        rst = 1'b0;
        stage_done = 1'b0; parity_valid = 1'b0; syndrome_zero = 1'b0;
        tick();
        $display("test_back_to_back: stages=%0d residence_errors=%0d", stages, bad);
    endtask

    initial begin
        test_reset();
        test_converge();
        test_max_iter();
        test_bad_config();
        test_watchdog();
        test_abort_last_row();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
